// File: rtl/data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit
//
// Memory-stage responder for load/store control codes produced in ID.
// Loads are formatted (byte/half extraction with sign or zero extension).
// The backing memory is word-wide without byte enables, so sub-word stores
// are done as a read-modify-write. busywait stalls the pipeline while a
// transaction is in flight.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-low
//   address        byte address from ALU result
//   write_data     store data (rs2)
//   mem_read       [3] load enable, [2:0] funct3
//   mem_write      [2] store enable, [1:0] size (00 SB, 01 SH, 10 SW)
//   read_data      formatted load result, registered
//   busywait       stall request to pipeline (combinational)
//   misalign_fault access misaligned (combinational)
//   mem_req        backing memory request, registered
//   mem_we         1 = write, 0 = read, registered
//   mem_addr       backing memory word address, registered
//   mem_wdata      backing memory write word, registered
//   mem_rdata      backing memory read word, valid with mem_ack
//   mem_ack        one-cycle completion pulse
// -----------------------------------------------------------------------------
module data_mem_access_unit #(
  parameter int MEM_ADDR_WIDTH = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               address,
  input  logic [31:0]               write_data,
  input  logic [3:0]                mem_read,
  input  logic [2:0]                mem_write,
  output logic [31:0]               read_data,
  output logic                      busywait,
  output logic                      misalign_fault,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_ack
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } state_t;

  state_t state;

  // Request decode. A load wins over a simultaneous store.
  logic       load_en;
  logic       store_en;
  logic       req;
  logic [1:0] size_code;
  logic       is_byte;
  logic       is_half;
  logic       is_word;
  logic       misaligned;
  logic       aligned_req;

  assign load_en     = mem_read[3];
  assign store_en    = mem_write[2] & ~load_en;
  assign req         = load_en | store_en;
  assign size_code   = load_en ? mem_read[1:0] : mem_write[1:0];
  // Undefined size encodings (funct3 011/110/111, store size 11) act as word.
  assign is_byte     = (size_code == 2'b00);
  assign is_half     = (size_code == 2'b01);
  assign is_word     = size_code[1];
  assign misaligned  = (is_half & address[0]) | (is_word & (address[1:0] != 2'b00));
  assign aligned_req = req & ~misaligned;

  // Both flags are forced low while reset is asserted, independent of state.
  assign busywait       = reset & aligned_req & (state != DONE);
  assign misalign_fault = reset & req & misaligned;

  // Load formatting and sub-word merge, both taken from the word on mem_rdata.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        load_unsigned;
  logic [31:0] load_fmt;
  logic [31:0] rmw_word;

  assign load_unsigned = mem_read[2];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sel_byte = mem_rdata[7:0];
    sel_half = mem_rdata[15:0];
    load_fmt = mem_rdata;
    rmw_word = mem_rdata;

    case (address[1:0])
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = address[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    if (is_byte) begin
      load_fmt = {{24{~load_unsigned & sel_byte[7]}}, sel_byte};
    end else if (is_half) begin
      load_fmt = {{16{~load_unsigned & sel_half[15]}}, sel_half};
    end

    if (is_byte) begin
      case (address[1:0])
        2'd0:    rmw_word[7:0]   = write_data[7:0];
        2'd1:    rmw_word[15:8]  = write_data[7:0];
        2'd2:    rmw_word[23:16] = write_data[7:0];
        default: rmw_word[31:24] = write_data[7:0];
      endcase
    end else if (address[1]) begin
      rmw_word[31:16] = write_data[15:0];
    end else begin
      rmw_word[15:0] = write_data[15:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      read_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aligned_req) begin
            mem_req  <= 1'b1;
            mem_addr <= address[MEM_ADDR_WIDTH+1:2];
            if (load_en) begin
              mem_we <= 1'b0;
              state  <= RD;
            end else if (is_word) begin
              mem_we    <= 1'b1;
              mem_wdata <= write_data;
              state     <= WR;
            end else begin
              // Sub-word store: fetch the enclosing word first.
              mem_we <= 1'b0;
              state  <= RMW_RD;
            end
          end
        end
        RD: begin
          if (mem_ack) begin
            read_data <= load_fmt;
            mem_req   <= 1'b0;
            state     <= DONE;
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        RMW_RD: begin
          // mem_req stays high; the request simply turns into a write.
          if (mem_ack) begin
            mem_we    <= 1'b1;
            mem_wdata <= rmw_word;
            state     <= RMW_WR;
          end
        end
        RMW_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          // busywait is low here, so the pipeline advances on this edge.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_data_mem_access_unit
//
// Drives directed and randomized loads/stores into data_mem_access_unit while
// acting as the word-wide backing memory with a programmable ack delay. The
// expected load values, stored words, stall lengths and request counts come
// from a byte-level reference model of load/store semantics.
// -----------------------------------------------------------------------------
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] read_data;
  logic        busywait;
  logic        misalign_fault;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  data_mem_access_unit #(.MEM_ADDR_WIDTH(30)) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .write_data     (write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .read_data      (read_data),
    .busywait       (busywait),
    .misalign_fault (misalign_fault),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Backing memory: 16 words, indexed by byte address bits [5:2].
  logic [31:0] mem [16];
  // Last value a completed load should have left in read_data.
  logic [31:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int code_size(input logic [1:0] code);
    if (code == 2'b00) return 1;
    if (code == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] size_mask(input int size);
    if (size == 1) return 32'h0000_00FF;
    if (size == 2) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr,
                                              input int size, input bit uns);
    logic [31:0] mask;
    logic [31:0] v;
    int          sh;
    if (size == 4) return w;
    mask = size_mask(size);
    sh   = 8 * int'(addr % 4);
    v    = (w >> sh) & mask;
    if (!uns && (v > (mask >> 1))) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [31:0] addr, input int size);
    logic [31:0] mask;
    int          sh;
    if (size == 4) return wd;
    mask = size_mask(size);
    sh   = 8 * int'(addr % 4);
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // One pipeline instruction: drive it, serve the backing memory with `dly`
  // wait cycles before each ack, and check everything once busywait drops.
  task automatic run_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] rd, input logic [2:0] wr, input int dly);
    int          busy = 0;
    int          reqs = 0;
    int          writes = 0;
    int          wcnt = 0;
    int          size;
    int          phases;
    int          exp_busy;
    bit          is_load;
    bit          is_store;
    bit          mis;
    bit          timed_out = 1'b1;
    logic [29:0] first_addr = '0;
    logic [29:0] waddr = '0;
    logic [31:0] old_word;
    int          idx;

    idx      = int'(addr[5:2]);
    is_load  = rd[3];
    is_store = wr[2] && !is_load;
    size     = is_load ? code_size(rd[1:0]) : code_size(wr[1:0]);
    mis      = (is_load || is_store) && ((addr % size) != 0);
    old_word = mem[idx];
    phases   = (is_store && size < 4) ? 2 : 1;
    exp_busy = (!(is_load || is_store) || mis) ? 0 : 1 + phases * (dly + 1);

    @(negedge clk);
    mem_ack    = 1'b0;
    address    = addr;
    write_data = wdata;
    mem_read   = rd;
    mem_write  = wr;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!busywait) begin
        timed_out = 1'b0;
        break;
      end
      busy++;
      if (mem_req) begin
        if (reqs == 0) first_addr = mem_addr;
        reqs++;
        if (wcnt == dly) begin
          wcnt    = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            writes++;
            waddr = mem_addr;
            mem[mem_addr[3:0]] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr[3:0]];
          end
        end else begin
          wcnt++;
          mem_rdata = $urandom;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end

    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_busy_cycles"}, busy, exp_busy);
    check({tag, "_req_cycles"}, reqs, (exp_busy == 0) ? 0 : phases * (dly + 1));
    check({tag, "_misalign"}, misalign_fault, mis);
    check({tag, "_req_done"}, mem_req, 1'b0);
    check({tag, "_writes"}, writes, (is_store && !mis) ? 1 : 0);
    if (is_load && !mis) exp_rd = model_load(old_word, addr, size, rd[2]);
    check({tag, "_read_data"}, read_data, exp_rd);
    if (exp_busy != 0) check({tag, "_addr"}, {2'b00, first_addr}, {2'b00, addr[31:2]});
    if (is_store && !mis) begin
      check({tag, "_waddr"}, {2'b00, waddr}, {2'b00, addr[31:2]});
      check({tag, "_mem_word"}, mem[idx], model_store(old_word, wdata, addr, size));
    end
    if (mis) begin
      // Faulting access must never touch memory, even if held.
      repeat (2) begin
        @(negedge clk);
        #1;
        check({tag, "_mis_noreq"}, mem_req, 1'b0);
        check({tag, "_mis_nobusy"}, busywait, 1'b0);
      end
    end
    mem_read  = 4'b0;
    mem_write = 3'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  rd;
    logic [2:0]  wr;
    int          kind;

    reset      = 1'b1;
    address    = '0;
    write_data = '0;
    mem_read   = '0;
    mem_write  = '0;
    mem_rdata  = '0;
    mem_ack    = 1'b0;
    exp_rd     = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    #1 reset = 1'b0;
    #1;
    check("rst_read_data", read_data, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busywait", busywait, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset during an RD wait abandons the transaction at once.
    @(negedge clk);
    address  = 32'h0000_0040;
    mem_read = 4'b1010;
    repeat (2) @(negedge clk);
    #1;
    check("mid_req_before", mem_req, 1'b1);
    check("mid_busy_before", busywait, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_req_reset", mem_req, 1'b0);
    check("mid_busy_reset", busywait, 1'b0);
    check("mid_mis_reset", misalign_fault, 1'b0);
    mem_read = 4'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("idle_req", mem_req, 1'b0);
    check("idle_busy", busywait, 1'b0);
    check("idle_we", mem_we, 1'b0);
    check("idle_addr", {2'b00, mem_addr}, 32'h0);
    check("idle_wdata", mem_wdata, 32'h0);
    check("idle_read_data", read_data, 32'h0);

    // Directed loads on word 0x80FF7F01.
    mem[0] = 32'h80FF_7F01;
    run_op("lb", 32'h103, 32'h0, 4'b1000, 3'b000, 0);
    check("lb_const", read_data, 32'hFFFF_FF80);
    run_op("lbu", 32'h103, 32'h0, 4'b1100, 3'b000, 0);
    check("lbu_const", read_data, 32'h0000_0080);
    run_op("lh", 32'h102, 32'h0, 4'b1001, 3'b000, 0);
    check("lh_const", read_data, 32'hFFFF_80FF);
    run_op("lw_slow", 32'h100, 32'h0, 4'b1010, 3'b000, 3);
    check("lw_const", read_data, 32'h80FF_7F01);

    // Directed sub-word stores.
    mem[8] = 32'h1122_3344;
    run_op("sb", 32'h21, 32'h0000_00AB, 4'b0000, 3'b100, 0);
    check("sb_const", mem[8], 32'h1122_AB44);
    mem[8] = 32'h1122_3344;
    run_op("sh", 32'h22, 32'h0000_BEEF, 4'b0000, 3'b101, 0);
    check("sh_const", mem[8], 32'hBEEF_3344);

    // Misaligned and conflicting requests.
    run_op("lw_mis", 32'h102, 32'h0, 4'b1010, 3'b000, 0);
    run_op("conflict", 32'h104, 32'hDEAD_BEEF, 4'b1010, 3'b110, 1);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      a    = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      kind = $urandom_range(0, 9);
      rd   = 4'b0;
      wr   = 3'b0;
      if (kind < 5) begin
        rd = {1'b1, 3'($urandom)};
        if ($urandom_range(0, 3) == 0) wr = 3'($urandom);
      end else if (kind < 9) begin
        wr = {1'b1, 2'($urandom)};
      end else begin
        wr = {1'b0, 2'($urandom)};
      end
      run_op($sformatf("rnd%0d", n), a, $urandom, rd, wr, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Memory-stage responder for the load/store control codes generated in ID: mem_read[3:0] = {load_en, funct3} and mem_write[2:0] = {store_en, funct3[1:0]}.
- Formats loads: byte/half extraction with sign or zero extension.
- Performs sub-word stores as read-modify-write, because the backing data memory is word-wide and has no byte enables.
- Stalls the pipeline via busywait while a transaction is in flight.

Parameters:
- MEM_ADDR_WIDTH, 30, width of word address to backing memory (byte address bits [MEM_ADDR_WIDTH+1:2]).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; reset==0 forces the reset state immediately.
- address  in  32  byte address from ALU result.
- write_data  in  32  store data (rs2).
- mem_read  in  4  [3] load enable, [2:0] funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- mem_write  in  3  [2] store enable, [1:0] size (00 SB, 01 SH, 10 SW).
- read_data  out  32  formatted load result, registered.
- busywait  out  1  stall request to pipeline.
- misalign_fault  out  1  access misaligned, combinational.
- mem_req  out  1  backing memory request, registered.
- mem_we  out  1  1 = write, 0 = read, registered.
- mem_addr  out  MEM_ADDR_WIDTH  word address, registered.
- mem_wdata  out  32  write word, registered.
- mem_rdata  in  32  read word, valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset values: read_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE. busywait=0 and misalign_fault=0 while reset==0.
- Request: req = mem_read[3] | mem_write[2]. If both are set, the load wins and the store is ignored. Undefined funct3 codes (011, 110, 111) are treated as LW / SW.
- Misaligned: halfword with address[0]=1, or word with address[1:0]!=0.
  - misalign_fault=1 and busywait=0.
  - No memory access; state stays IDLE; read_data unchanged.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, DONE.
- IDLE, aligned req at an edge:
  - Load or SW: go to RD or WR; mem_req=1, mem_addr=address word, mem_we per op, mem_wdata=write_data for SW.
  - SB or SH: go to RMW_RD with a read request.
- RD, on mem_ack: read_data <= formatted mem_rdata; mem_req<=0; go to DONE.
- WR, on mem_ack: mem_req<=0; go to DONE.
- RMW_RD, on mem_ack: go to RMW_WR with mem_req held 1 and mem_we<=1.
  - mem_wdata = mem_rdata with byte address[1:0] (SB) or half address[1] (SH) replaced by write_data[7:0] or [15:0].
- RMW_WR, on mem_ack: mem_req<=0; go to DONE.
- DONE: go to IDLE at the next edge regardless of inputs. The pipeline advances on this edge.
- busywait = aligned req & (state != DONE). Combinational, so it is high in the same cycle the request first appears.
- Pipeline holds address, write_data, mem_read and mem_write stable while busywait=1.
- Load formatting, with k=address[1:0]:
  - LB/LBU: byte k, sign/zero extended.
  - LH/LHU: half address[1], sign/zero extended.
  - LW: full word.
- Minimum stall with ack in the first mem_req cycle:
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
- mem_ack outside RD, WR, RMW_RD or RMW_WR is ignored.
- mem_req holds high and the address/data are stable until ack. There is no timeout.
- Reset asserted mid-transaction: immediate return to IDLE with mem_req=0. The outstanding transaction is abandoned; the backing memory must tolerate the dropped request.

Test Plan:
- Reset: reset=0 during an RD wait -> mem_req=0 and busywait=0 immediately; after release with no request, all outputs stay 0.
- LB, signed vs unsigned, mem_rdata=0x80FF7F01:
  - address=0x103 -> read_data=0xFFFFFF80.
  - Same with LBU -> 0x00000080.
  - LH at 0x102 -> 0xFFFF80FF.
  - busywait high exactly 2 cycles with immediate ack.
- LW with ack delayed 3 cycles -> busywait high 5 cycles; mem_req high 4 cycles; read_data=mem_rdata in DONE.
- SB read-modify-write: address=0x21, write_data=0x000000AB, memory word 0x11223344 -> read then write of 0x1122AB44 to word 0x8; busywait 3 cycles.
- SH read-modify-write: address=0x22, write_data=0xBEEF, word 0x11223344 -> writes 0xBEEF3344.
- Misaligned and conflicting requests:
  - LW at 0x102 -> misalign_fault=1, busywait=0, mem_req never asserted.
  - Simultaneous load and store enables -> load performed, no write issued.
